shift_add_mac: RTL

SHIFT_ADD_MAC -- requirements
Module: shift_add_mac

---
 rtl/shift_add_mac_if.sv | 28 ++
 rtl/shift_add_mac.sv | 109 ++++++++++
 2 files changed

// File: rtl/shift_add_mac_if.sv
// Bus between the shift-add multiply-accumulate unit and its requester.
// Handshake: start is a level request taken only when the unit is idle. done
// qualifies product and stays high until the next request is accepted.
// A request is re-armed only after start has been seen low.
interface shift_add_mac_if #(
  parameter int N = 64,
  parameter int M = 64
);
  logic             start;
  logic [N-1:0]     multiplicand;
  logic [M-1:0]     multiplier;
  logic [M-1:0]     addend;
  logic [N+M-1:0]   product;
  logic             done;
  logic             busy;
  logic [7:0]       cnt;
  logic [1:0]       state;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  product, done, busy, cnt, state
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output product, done, busy, cnt, state
  );
endinterface

// File: rtl/shift_add_mac.sv
// Sequential unsigned multiply-accumulate: product = A*B + C.
// One multiplier bit is consumed per clock, so a result takes M+1 cycles.
module shift_add_mac #(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_add_mac_if.slave     bus
);

  localparam int W = N + M;
  localparam logic [7:0] M_CNT = 8'(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   a_reg;
  logic [M-1:0]   b_reg;
  logic [W-1:0]   product_q;
  logic [7:0]     cnt_q;
  logic           done_q;
  logic           busy_q;

  logic           load;
  logic           step;
  logic           finish;
  logic [M-1:0]   b_shift;
  logic [W-1:0]   a_ext;

  assign b_shift = b_reg >> cnt_q;
  assign a_ext   = {{M{1'b0}}, a_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          load    = 1'b1;
        end
      end
      CALC: begin
        if (cnt_q == M_CNT) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        // Leaving DONE needs start low, so a held request cannot retrigger.
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (load) begin
      a_reg     <= bus.multiplicand;
      b_reg     <= bus.multiplier;
      product_q <= {{N{1'b0}}, bus.addend};
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else if (step) begin
      if (b_shift[0]) begin
        product_q <= product_q + (a_ext << cnt_q);
      end
      cnt_q <= cnt_q + 8'd1;
    end else if (finish) begin
      done_q <= 1'b1;
      busy_q <= 1'b0;
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.cnt     = cnt_q;
  assign bus.state   = state_q;

endmodule
